// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite movers: FSM states, per-axis direction
// codes and the default screen size.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  typedef logic [1:0] dir_t;

  localparam dir_t ZERO = 2'b00;
  localparam dir_t POS  = 2'b01;
  localparam dir_t NEG  = 2'b10;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Opposing buttons pressed together cancel out on that axis.
  function automatic dir_t resolve_dir(input logic fwd, input logic back);
    if (fwd && !back) return POS;
    else if (back && !fwd) return NEG;
    else return ZERO;
  endfunction

endpackage

// File: rtl/sprite_bounds_check.sv
// Registered "pixel inside W x H box at (x,y)" test; 1-cycle latency.
// Compares at POS_W+1 bits so a box touching the top of the range cannot wrap.
module sprite_bounds_check #(
  parameter int POS_W = 10,
  parameter int W     = 32,
  parameter int H     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] hc_i,
  input  logic [POS_W-1:0] vc_i,
  input  logic [POS_W-1:0] x_i,
  input  logic [POS_W-1:0] y_i,
  output logic             in_o
);

  logic [POS_W:0] hc_e, vc_e, x_lo, y_lo, x_hi, y_hi;
  logic           in_d, in_q;

  assign hc_e = {1'b0, hc_i};
  assign vc_e = {1'b0, vc_i};
  assign x_lo = {1'b0, x_i};
  assign y_lo = {1'b0, y_i};
  assign x_hi = x_lo + (POS_W+1)'(W - 1);
  assign y_hi = y_lo + (POS_W+1)'(H - 1);

  assign in_d = (hc_e >= x_lo) && (hc_e <= x_hi) &&
                (vc_e >= y_lo) && (vc_e <= y_hi);

  always_ff @(posedge clk) begin
    if (rst) in_q <= 1'b0;
    else     in_q <= in_d;
  end

  assign in_o = in_q;

endmodule

// File: rtl/sprite_mover.sv
// Player sprite controller: buttons -> bounded position with tap steps and
// hold-to-repeat, paced by frame_tick. Define SPRITE_MOVER_WRAP_EN to wrap X.
module sprite_mover
  import sprite_pkg::*;
#(
  parameter int POS_W        = 10,
  parameter int SPRITE_W     = 32,
  parameter int SPRITE_H     = 32,
  parameter int STEP         = 8,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = SCREEN_W - SPRITE_W,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = SCREEN_H - SPRITE_H,
  parameter int START_X      = 100,
  parameter int START_Y      = 240,
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 4,
  parameter int CNT_W        = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic [POS_W-1:0] hc,
  input  logic [POS_W-1:0] vc,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic             sprite_in,
  output logic             moved
);

  localparam int EW = POS_W + 1;
  localparam logic [EW-1:0] XLO = EW'(X_MIN);
  localparam logic [EW-1:0] XHI = EW'(X_MAX);
  localparam logic [EW-1:0] YLO = EW'(Y_MIN);
  localparam logic [EW-1:0] YHI = EW'(Y_MAX);
  localparam logic [EW-1:0] STP = EW'(STEP);

  function automatic logic [POS_W-1:0] step_sat(input logic [POS_W-1:0] pos,
                                                input dir_t d,
                                                input logic [EW-1:0] lo,
                                                input logic [EW-1:0] hi);
    logic [EW-1:0] p, r;
    p = {1'b0, pos};
    r = p;
    case (d)
      POS:     r = (p + STP > hi) ? hi : p + STP;
      NEG:     r = (p < lo + STP) ? lo : p - STP;
      default: r = p;
    endcase
    return r[POS_W-1:0];
  endfunction

`ifdef SPRITE_MOVER_WRAP_EN
  function automatic logic [POS_W-1:0] step_wrap(input logic [POS_W-1:0] pos,
                                                 input dir_t d,
                                                 input logic [EW-1:0] lo,
                                                 input logic [EW-1:0] hi);
    logic [EW-1:0] p, r;
    p = {1'b0, pos};
    r = p;
    case (d)
      POS:     r = (p + STP > hi) ? lo : p + STP;
      NEG:     r = (p < lo + STP) ? hi : p - STP;
      default: r = p;
    endcase
    return r[POS_W-1:0];
  endfunction
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       prev_q;
  logic [POS_W-1:0] pos_x_q, pos_y_q, pos_x_d, pos_y_d;
  logic             moved_q;
  dir_t             dx, dy;
  logic             any, dir_chg, step;

  assign dx      = resolve_dir(btn_right, btn_left);
  assign dy      = resolve_dir(btn_down, btn_up);
  assign any     = (dx != ZERO) || (dy != ZERO);
  assign dir_chg = ({dx, dy} != prev_q);

  // Counters compare their old value, so a hold steps on tick 1, then after
  // REPEAT_DELAY more ticks, then every REPEAT_RATE ticks.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step    = 1'b0;
    if (frame_tick) begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (any) begin
            step    = 1'b1;
            state_d = DELAY;
          end
        end
        DELAY: begin
          if (!any) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (dir_chg) begin
            step  = 1'b1;
            cnt_d = '0;
          end else if (cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
            step    = 1'b1;
            cnt_d   = '0;
            state_d = REPEAT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (!any) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (dir_chg) begin
            step    = 1'b1;
            cnt_d   = '0;
            state_d = DELAY;
          end else if (cnt_q == CNT_W'(REPEAT_RATE - 1)) begin
            step  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    if (step) begin
`ifdef SPRITE_MOVER_WRAP_EN
      pos_x_d = step_wrap(pos_x_q, dx, XLO, XHI);
`else
      pos_x_d = step_sat(pos_x_q, dx, XLO, XHI);
`endif
      pos_y_d = step_sat(pos_y_q, dy, YLO, YHI);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prev_q  <= '0;
      pos_x_q <= POS_W'(START_X);
      pos_y_q <= POS_W'(START_Y);
      moved_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (frame_tick) prev_q <= {dx, dy};
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      moved_q <= (pos_x_d != pos_x_q) || (pos_y_d != pos_y_q);
    end
  end

  sprite_bounds_check #(
    .POS_W (POS_W),
    .W     (SPRITE_W),
    .H     (SPRITE_H)
  ) u_bounds (
    .clk  (clk),
    .rst  (rst),
    .hc_i (hc),
    .vc_i (vc),
    .x_i  (pos_x_q),
    .y_i  (pos_y_q),
    .in_o (sprite_in)
  );

  assign pos_x = pos_x_q;
  assign pos_y = pos_y_q;
  assign moved = moved_q;

endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench for sprite_mover; expectations follow SPRITE_MOVER_WRAP_EN
// when the bench is built with it.
module tb_sprite_mover;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic [9:0] hc, vc;
  logic [9:0] pos_x, pos_y;
  logic       sprite_in, moved;

  int n_checks = 0;
  int n_pass   = 0;
  int moved_cnt = 0;
  logic tap_moved;
  logic [31:0] mask;

`ifdef SPRITE_MOVER_WRAP_EN
  localparam int EXP_UNDER = 608, EXP_OVER = 0, EXP_OVER2 = 8, EXP_OVER2_MV = 1;
`else
  localparam int EXP_UNDER = 0, EXP_OVER = 608, EXP_OVER2 = 608, EXP_OVER2_MV = 0;
`endif

  sprite_mover dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .hc         (hc),
    .vc         (vc),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .sprite_in  (sprite_in),
    .moved      (moved)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (moved === 1'b1) moved_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
  endtask

  task automatic set_btn(input logic u, input logic d, input logic l, input logic r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
  endtask

  task automatic tap(input logic u, input logic d, input logic l, input logic r);
    set_btn(u, d, l, r);
    tick();
    tap_moved = moved;
    set_btn(0, 0, 0, 0);
    tick();
  endtask

  task automatic probe(input int h, input int v, input logic exp);
    hc = 10'(h); vc = 10'(v);
    @(negedge clk);
    check($sformatf("sprite_in(%0d,%0d)", h, v), {31'd0, sprite_in}, {31'd0, exp});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; frame_tick = 1'b0; hc = '0; vc = '0;
    set_btn(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_x", pos_x, 100);
    check("rst_y", pos_y, 240);
    check("rst_moved", {31'd0, moved}, 0);
    check("rst_in", {31'd0, sprite_in}, 0);
    rst = 1'b0;
    moved_cnt = 0;

    repeat (5) tick();
    check("idle_moved_cnt", moved_cnt, 0);
    check("idle_x", pos_x, 100);
    probe(100, 240, 1); probe(131, 271, 1); probe(115, 255, 1);
    probe(99, 240, 0);  probe(132, 240, 0); probe(100, 239, 0);
    probe(100, 272, 0); probe(131, 272, 0);
    hc = '0; vc = '0;

    // Single right tap
    moved_cnt = 0;
    btn_right = 1'b1;
    tick();
    check("right_x", pos_x, 108);
    check("right_moved", {31'd0, moved}, 1);
    btn_right = 1'b0;
    @(negedge clk);
    check("moved_one_cycle", {31'd0, moved}, 0);
    tick();
    check("right_moved_cnt", moved_cnt, 1);

    // Hold down 30 ticks: steps at 1, 21, 25, 29
    mask = '0;
    btn_down = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (moved) mask[k] = 1'b1;
    end
    btn_down = 1'b0;
    check("hold_mask", mask, 32'h2220_0002);
    check("hold_y", pos_y, 272);
    tick();

    // Opposing horizontal plus down
    tap(0, 1, 1, 1);
    check("diag_x", pos_x, 108);
    check("diag_y", pos_y, 280);
    check("diag_moved", {31'd0, tap_moved}, 1);

    // Direction change during DELAY steps immediately
    set_btn(1, 0, 0, 0);
    repeat (3) tick();
    check("chg_pre_y", pos_y, 272);
    set_btn(0, 0, 1, 0);
    tick();
    check("chg_x", pos_x, 100);
    check("chg_moved", {31'd0, moved}, 1);
    set_btn(0, 0, 0, 0);
    tick();

    // Up to the top bound, then push against it
    repeat (34) tap(1, 0, 0, 0);
    check("top_y", pos_y, 0);
    tap(1, 0, 0, 0);
    check("top_sat_y", pos_y, 0);
    check("top_sat_moved", {31'd0, tap_moved}, 0);

    // Left from 4: underflow saturates (or wraps)
    repeat (12) tap(0, 0, 1, 0);
    check("left4_x", pos_x, 4);
    tap(0, 0, 1, 0);
    check("under_x", pos_x, EXP_UNDER);
    check("under_moved", {31'd0, tap_moved}, 1);

    // Reset aborts a hold in progress
    set_btn(0, 1, 0, 0);
    repeat (3) tick();
    check("abort_pre_y", pos_y, 8);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_x", pos_x, 100);
    check("abort_y", pos_y, 240);
    rst = 1'b0;
    tick();
    check("abort_step_y", pos_y, 248);
    check("abort_step_moved", {31'd0, moved}, 1);
    set_btn(0, 0, 0, 0);
    tick();

    // Right edge
    repeat (63) tap(0, 0, 0, 1);
    check("right604_x", pos_x, 604);
    tap(0, 0, 0, 1);
    check("over_x", pos_x, EXP_OVER);
    check("over_moved", {31'd0, tap_moved}, 1);
    tap(0, 0, 0, 1);
    check("over2_x", pos_x, EXP_OVER2);
    check("over2_moved", {31'd0, tap_moved}, EXP_OVER2_MV);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
